steer_en_sm: RTL and testbench
==============================

# steer_en_sm

Rider-presence and steering-enable controller, directly downstream of the A2D interface. It consumes the round-robin `lft_ld` and `rght_ld` load-cell readings. It decides whether a rider is on the platform and whether the rider has been balanced long enough to enable steering. Its outputs `en_steer` and `rider_off` feed the balance controller and the steering/torque path.

## Interface
Parameters:
- `FAST_SIM`, default 0: when 1, the settle timer terminal count is 2^15−1 instead of 2^26−1 (≈1.34 s at 50 MHz).
- `MIN_RIDER_WT`, default 12'h200: rider-present threshold on the summed load.
- `WT_HYSTERESIS`, default 12'h040: hysteresis subtracted from `MIN_RIDER_WT` for the rider-off threshold.

Ports:
- `clk`  in  1: system clock, all logic on the rising edge.
- `rst`  in  1: reset. **Synchronous, active-high.**
- `lft_ld`  in  12: left load-cell reading, unsigned. Held between A2D updates.
- `rght_ld`  in  12: right load-cell reading, unsigned.
- `en_steer`  out  1: steering enabled (rider on and balanced).
- `rider_off`  out  1: no rider detected.

## Operation
Arithmetic is combinational from the inputs and fully unsigned:
- `sum = lft_ld + rght_ld`, 13 bits, no overflow.
- `diff = |lft_ld − rght_ld|`, 12 bits, zero-extended to 13 bits for compares.
- `rider_on = sum > MIN_RIDER_WT` (strict).
- `rider_gone = sum < MIN_RIDER_WT − WT_HYSTERESIS` (strict). With the defaults the threshold is 12'h1C0.
- `unbal_1_4 = diff > (sum >> 2)`.
- `unbal_15_16 = diff > (sum − (sum >> 4))`.

Settle timer:
- 26-bit up-counter, synchronous clear `clr_tmr`.
- It increments every cycle in WAIT, saturates at its terminal count, and is held at 0 in the other states.
- `tmr_full` = count equals the terminal count.

State machine, states IDLE, WAIT, STEER:
- IDLE:
  - If `rider_on`, go to WAIT and assert `clr_tmr`.
  - Otherwise stay in IDLE.
- WAIT, conditions in priority order:
  - `rider_gone` → IDLE.
  - `unbal_1_4` → stay in WAIT and assert `clr_tmr`.
  - `tmr_full` → STEER.
  - Otherwise stay in WAIT and count.
- STEER, conditions in priority order:
  - `rider_gone` → IDLE.
  - `unbal_15_16` → WAIT and assert `clr_tmr`.
  - Otherwise stay in STEER.

Outputs are decoded from the registered state (Moore):
- `en_steer = (state == STEER)`.
- `rider_off = (state == IDLE)`.

Boundary conditions:
- `sum` exactly equal to `MIN_RIDER_WT`: not `rider_on`, so the block stays in IDLE.
- `sum` exactly equal to the rider-gone threshold: not `rider_gone`.
- `sum == 0`: `unbal_*` are false and `rider_gone` is true, so the block goes to IDLE.
- `rider_gone` and an unbalance condition in the same cycle: `rider_gone` wins.
- Timer at terminal count: it saturates and does not wrap.

## Timing
- Reset (`rst` high at a clock edge): state = IDLE, timer = 0, `en_steer` = 0, `rider_off` = 1.
- Reset asserted mid-WAIT or mid-STEER has the same effect on the next edge. It overrides all transitions.
- An input change is reflected in the outputs 1 cycle later (one state register, no input pipelining).
- IDLE→WAIT: `rider_off` falls on the edge after `rider_on` is first sampled high.
- WAIT→STEER: `en_steer` rises N+2 edges after entering WAIT with balanced load, where N is the terminal count (clear cycle plus N increments plus transition). With `FAST_SIM`=1, N = 32767.
- Any `unbal_1_4` cycle in WAIT restarts the full count.

## Structure
- Package `steer_pkg` holds:
  - the `state_t` enum {IDLE, WAIT, STEER};
  - the terminal count constants `TMR_FULL_SIM` = 26'h0007FFF and `TMR_FULL` = 26'h3FFFFFF;
  - the default thresholds.
- Sub-module `settle_tmr` contains the counter, with ports `clk`, `rst`, `clr`, `en`, `full`, and a `FAST_SIM` parameter.
- The FSM, the arithmetic and the output decode live in `steer_en_sm`.

## Test plan
All scenarios use `FAST_SIM`=1.
1. Reset: drive `rst`=1 with `lft_ld` = `rght_ld` = 12'h300 → `rider_off`=1 and `en_steer`=0 for as long as `rst` is high. Release reset → `rider_off`=0 one cycle later.
2. Mount and settle: `lft_ld` = `rght_ld` = 12'h180 (sum 0x300) → WAIT, then `en_steer`=1 exactly 32769 cycles after entry.
3. Unbalance restart: in WAIT after 20000 cycles, set `lft_ld`=12'h280 and `rght_ld`=12'h080 (diff 0x200 > 0xC0) for 1 cycle, then rebalance → `en_steer` rises 32769 cycles after rebalance. Check that it is not high at 12769.
4. Steer drop: in STEER, set `lft_ld`=12'h2F8 and `rght_ld`=12'h008 (diff 0x2F0 > 0x2D0) → WAIT next cycle, `en_steer`=0, `rider_off`=0. Then `lft_ld`=12'h200 and `rght_ld`=12'h100 (diff 0x100 < 0x2D0) keeps STEER.
5. Hysteresis edges: from IDLE, sum = 12'h200 → stays IDLE. Sum = 12'h201 → WAIT. Then sum = 12'h1C0 → stays WAIT. Sum = 12'h1BF → IDLE, `rider_off`=1.
6. Priority: in STEER, apply `lft_ld`=12'h1BF and `rght_ld`=0 (both `rider_gone` and `unbal_15_16`) → IDLE, not WAIT.

Source files
------------

// File: rtl/steer_pkg.sv
// -----------------------------------------------------------------------------
// steer_pkg
// Shared types and constants for the rider-presence / steering-enable block.
//   state_t          : controller states IDLE, WAIT, STEER
//   TMR_FULL_SIM     : settle timer terminal count for fast simulation
//   TMR_FULL         : settle timer terminal count for silicon (~1.34 s @ 50 MHz)
//   MIN_RIDER_WT_DEF : default rider-present threshold on the summed load
//   WT_HYST_DEF      : default hysteresis below the rider-present threshold
// -----------------------------------------------------------------------------
package steer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } state_t;

    localparam logic [25:0] TMR_FULL_SIM     = 26'h0007FFF;
    localparam logic [25:0] TMR_FULL         = 26'h3FFFFFF;

    localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
    localparam logic [11:0] WT_HYST_DEF      = 12'h040;

    // Absolute difference of two unsigned load readings; never negative,
    // so it always fits in the input width.
    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] res;
        if (a > b) begin
            res = a - b;
        end else begin
            res = b - a;
        end
        return res;
    endfunction

    // Terminal count selected by the simulation-speed switch.
    function automatic logic [25:0] tmr_term(input bit fast_sim);
        logic [25:0] res;
        if (fast_sim) begin
            res = TMR_FULL_SIM;
        end else begin
            res = TMR_FULL;
        end
        return res;
    endfunction

endpackage

// File: rtl/settle_tmr.sv
// -----------------------------------------------------------------------------
// settle_tmr
// 26-bit saturating settle timer. Counts up while enabled, holds at the
// terminal count instead of wrapping, and clears synchronously.
// Ports:
//   clk  in  1 : system clock, rising edge
//   rst  in  1 : synchronous active-high reset
//   clr  in  1 : synchronous clear (wins over en)
//   en   in  1 : count enable
//   full out 1 : count has reached the terminal count
// -----------------------------------------------------------------------------
module settle_tmr
    import steer_pkg::*;
#(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic full
);

    localparam logic [25:0] TERM = tmr_term(FAST_SIM);

    logic [25:0] cnt_r;

    // Counter register: clear has priority, then saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 26'd0;
        end else if (clr) begin
            cnt_r <= 26'd0;
        end else if (en) begin
            if (cnt_r != TERM) begin
                cnt_r <= cnt_r + 26'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign full = (cnt_r == TERM);

endmodule

// File: rtl/steer_en_sm.sv
// -----------------------------------------------------------------------------
// steer_en_sm
// Rider-presence and steering-enable controller. Decides from the summed and
// differential load-cell readings whether a rider is on the platform and
// whether the rider has stayed balanced long enough to enable steering.
// Ports:
//   clk       in  1  : system clock, rising edge
//   rst       in  1  : synchronous active-high reset
//   lft_ld    in  12 : left load-cell reading, unsigned
//   rght_ld   in  12 : right load-cell reading, unsigned
//   en_steer  out 1  : steering enabled (state STEER), registered
//   rider_off out 1  : no rider (state IDLE), registered
// -----------------------------------------------------------------------------
module steer_en_sm
    import steer_pkg::*;
#(
    parameter bit          FAST_SIM      = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYSTERESIS = WT_HYST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam logic [12:0] ON_THR   = {1'b0, MIN_RIDER_WT};
    localparam logic [11:0] GONE_12  = MIN_RIDER_WT - WT_HYSTERESIS;
    localparam logic [12:0] GONE_THR = {1'b0, GONE_12};

    state_t      state_r;
    logic [12:0] sum_s;
    logic [12:0] diff_s;
    logic        rider_on_s;
    logic        rider_gone_s;
    logic        unbal_1_4_s;
    logic        unbal_15_16_s;
    logic        clr_tmr_s;
    logic        tmr_en_s;
    logic        tmr_full_s;

    // Load arithmetic: 13-bit sum cannot overflow, diff is zero-extended.
    assign sum_s  = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff_s = {1'b0, abs_diff(lft_ld, rght_ld)};

    assign rider_on_s    = (sum_s > ON_THR);
    assign rider_gone_s  = (sum_s < GONE_THR);
    assign unbal_1_4_s   = (diff_s > {2'b00, sum_s[12:2]});
    assign unbal_15_16_s = (diff_s > (sum_s - {4'b0000, sum_s[12:4]}));

    // Timer clear: the timer only runs in WAIT, so it is held clear in every
    // other state; inside WAIT an unbalance restarts it unless the rider is
    // leaving (the IDLE transition takes priority and clears it anyway).
    always_comb begin
        clr_tmr_s = 1'b1;
        case (state_r)
            IDLE: begin
                clr_tmr_s = 1'b1;
            end
            WAIT: begin
                if (!rider_gone_s && unbal_1_4_s) begin
                    clr_tmr_s = 1'b1;
                end else begin
                    clr_tmr_s = 1'b0;
                end
            end
            STEER: begin
                clr_tmr_s = 1'b1;
            end
            default: begin
                clr_tmr_s = 1'b1;
            end
        endcase
    end

    assign tmr_en_s = (state_r == WAIT);

    settle_tmr #(
        .FAST_SIM (FAST_SIM)
    ) u_settle_tmr (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_tmr_s),
        .en   (tmr_en_s),
        .full (tmr_full_s)
    );

    // Controller FSM; the outputs are loaded with the decode of the next
    // state so they always match the state register (Moore, registered).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rider_on_s) begin
                        state_r   <= WAIT;
                        en_steer  <= 1'b0;
                        rider_off <= 1'b0;
                    end else begin
                        state_r   <= IDLE;
                        en_steer  <= 1'b0;
                        rider_off <= 1'b1;
                    end
                end
                WAIT: begin
                    if (rider_gone_s) begin
                        state_r   <= IDLE;
                        en_steer  <= 1'b0;
                        rider_off <= 1'b1;
                    end else if (unbal_1_4_s) begin
                        state_r   <= WAIT;
                        en_steer  <= 1'b0;
                        rider_off <= 1'b0;
                    end else if (tmr_full_s) begin
                        state_r   <= STEER;
                        en_steer  <= 1'b1;
                        rider_off <= 1'b0;
                    end else begin
                        state_r   <= WAIT;
                        en_steer  <= 1'b0;
                        rider_off <= 1'b0;
                    end
                end
                STEER: begin
                    if (rider_gone_s) begin
                        state_r   <= IDLE;
                        en_steer  <= 1'b0;
                        rider_off <= 1'b1;
                    end else if (unbal_15_16_s) begin
                        state_r   <= WAIT;
                        en_steer  <= 1'b0;
                        rider_off <= 1'b0;
                    end else begin
                        state_r   <= STEER;
                        en_steer  <= 1'b1;
                        rider_off <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    en_steer  <= 1'b0;
                    rider_off <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_steer_en_sm.sv
// -----------------------------------------------------------------------------
// tb_steer_en_sm
// Self-checking bench for steer_en_sm with FAST_SIM=1. Each stimulus cycle
// advances a small behavioural model, pushes the expected {en_steer,
// rider_off} into a scoreboard queue, and the value is popped and compared
// one edge later. Scenario checks at the notable cycles are added on top.
// -----------------------------------------------------------------------------
module tb_steer_en_sm;

    localparam int N = 32767;  // FAST_SIM terminal count

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lft_ld = 12'h000;
    logic [11:0] rght_ld = 12'h000;
    logic        en_steer;
    logic        rider_off;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];

    // Reference model state: 0 = IDLE, 1 = WAIT, 2 = STEER
    int m_st = 0;
    int m_t  = 0;

    steer_en_sm #(
        .FAST_SIM      (1'b1),
        .MIN_RIDER_WT  (12'h200),
        .WT_HYSTERESIS (12'h040)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    // 100 MHz bench clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge given the inputs sampled on it.
    task automatic model_edge(input logic r, input int l, input int g);
        int  s;
        int  d;
        bit  on;
        bit  gone;
        bit  u14;
        bit  u1516;
        s     = l + g;
        d     = (l > g) ? (l - g) : (g - l);
        on    = (s > 32'h200);
        gone  = (s < 32'h1C0);
        u14   = (d > s / 4);
        u1516 = (d > s - s / 16);
        if (r) begin
            m_st = 0;
            m_t  = 0;
        end else begin
            case (m_st)
                0: if (on) begin m_st = 1; m_t = 0; end
                1: begin
                    if (gone)           begin m_st = 0; m_t = 0; end
                    else if (u14)       m_t = 0;
                    else if (m_t == N)  m_st = 2;
                    else                m_t = m_t + 1;
                end
                2: begin
                    if (gone)           begin m_st = 0; m_t = 0; end
                    else if (u1516)     begin m_st = 1; m_t = 0; end
                end
                default: m_st = 0;
            endcase
        end
    endtask

    // Drive one cycle, push the expectation, compare after the edge.
    task automatic step(input logic r, input logic [11:0] l, input logic [11:0] g);
        logic [1:0] e;
        rst     = r;
        lft_ld  = l;
        rght_ld = g;
        model_edge(r, int'(l), int'(g));
        exp_q.push_back({(m_st == 2), (m_st == 0)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("cycle_outputs", {30'd0, en_steer, rider_off}, {30'd0, e});
    endtask

    task automatic run(input int n, input logic [11:0] l, input logic [11:0] g);
        for (int i = 0; i < n; i++) begin
            step(1'b0, l, g);
        end
    endtask

    initial begin
        // 1. Reset holds IDLE even with a heavy rider on the platform
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 12'h300, 12'h300);
            check_eq("rst_rider_off", {31'd0, rider_off}, 32'd1);
            check_eq("rst_en_steer",  {31'd0, en_steer},  32'd0);
        end
        step(1'b0, 12'h300, 12'h300);
        check_eq("rel_rider_off", {31'd0, rider_off}, 32'd0);
        step(1'b1, 12'h000, 12'h000);
        check_eq("rst_again_off", {31'd0, rider_off}, 32'd1);

        // 2. Mount and settle: entry edge is cycle 1, en_steer at cycle N+2
        step(1'b0, 12'h180, 12'h180);
        check_eq("mount_rider_off", {31'd0, rider_off}, 32'd0);
        run(N, 12'h180, 12'h180);
        check_eq("settle_early", {31'd0, en_steer}, 32'd0);
        step(1'b0, 12'h180, 12'h180);
        check_eq("settle_rise", {31'd0, en_steer}, 32'd1);

        // 4. Moderate imbalance keeps STEER, severe imbalance drops to WAIT
        step(1'b0, 12'h200, 12'h100);
        check_eq("steer_keep", {31'd0, en_steer}, 32'd1);
        step(1'b0, 12'h2F8, 12'h008);
        check_eq("steer_drop_en",  {31'd0, en_steer},  32'd0);
        check_eq("steer_drop_off", {31'd0, rider_off}, 32'd0);

        // 3. Unbalance restart after 20000 WAIT cycles. The unbalanced cycle
        //    is the clear edge (cycle 1); the rise is at cycle N+2 from it.
        run(20000, 12'h180, 12'h180);
        check_eq("wait_20000", {31'd0, en_steer}, 32'd0);
        step(1'b0, 12'h280, 12'h080);
        run(12769, 12'h180, 12'h180);
        check_eq("restart_12769", {31'd0, en_steer}, 32'd0);
        run(N + 1 - 12770, 12'h180, 12'h180);
        check_eq("restart_early", {31'd0, en_steer}, 32'd0);
        step(1'b0, 12'h180, 12'h180);
        check_eq("restart_rise", {31'd0, en_steer}, 32'd1);

        // 6. rider_gone beats unbal_15_16 in STEER
        step(1'b0, 12'h1BF, 12'h000);
        check_eq("prio_rider_off", {31'd0, rider_off}, 32'd1);
        check_eq("prio_en_steer",  {31'd0, en_steer},  32'd0);

        // 5. Threshold and hysteresis edges
        step(1'b0, 12'h100, 12'h100);
        check_eq("sum_eq_min", {31'd0, rider_off}, 32'd1);
        step(1'b0, 12'h101, 12'h100);
        check_eq("sum_above_min", {31'd0, rider_off}, 32'd0);
        step(1'b0, 12'h0E0, 12'h0E0);
        check_eq("sum_eq_gone", {31'd0, rider_off}, 32'd0);
        step(1'b0, 12'h0E0, 12'h0DF);
        check_eq("sum_below_gone", {31'd0, rider_off}, 32'd1);

        // Zero load: stays in IDLE, and leaves WAIT for IDLE
        step(1'b0, 12'h000, 12'h000);
        check_eq("zero_idle", {31'd0, rider_off}, 32'd1);
        step(1'b0, 12'h101, 12'h100);
        step(1'b0, 12'h000, 12'h000);
        check_eq("zero_from_wait", {31'd0, rider_off}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
